// File: rtl/regfile_writeback_if.sv
// Purpose : bundle of result, issue, query and register-file write signals for regfile_writeback.
// Latency : n/a (wiring only); fifo_count width tracks DEPTH.
// Backpressure: lu_valid/lu_ready handshake on the long-unit path; ALU and issue paths have none.
//
// Port summary (slave = writeback block, master = surrounding pipeline / bench):
//   flush                              sync flush of FIFO and scoreboard
//   alu_valid/alu_fp/alu_rd/alu_data   single-cycle result, always accepted
//   lu_valid/lu_ready/lu_fp/lu_rd/lu_data  long-unit result handshake
//   issue_valid/issue_fp/issue_rd      long-unit op issued, mark dest pending
//   q_fp/q_rs/q_rt -> rs_busy/rt_busy  RAW hazard lookup
//   wr_en/wr_fp/wr_addr/wr_data        register-file write port
//   fifo_count                         long-unit FIFO occupancy
interface regfile_writeback_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;

    logic          alu_valid;
    logic          alu_fp;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;

    logic          lu_valid;
    logic          lu_ready;
    logic          lu_fp;
    logic [4:0]    lu_rd;
    logic [31:0]   lu_data;

    logic          issue_valid;
    logic          issue_fp;
    logic [4:0]    issue_rd;

    logic          q_fp;
    logic [4:0]    q_rs;
    logic [4:0]    q_rt;
    logic          rs_busy;
    logic          rt_busy;

    logic          wr_en;
    logic          wr_fp;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;

    logic [CW-1:0] fifo_count;

    modport slave (
        input  flush,
        input  alu_valid, alu_fp, alu_rd, alu_data,
        input  lu_valid, lu_fp, lu_rd, lu_data,
        output lu_ready,
        input  issue_valid, issue_fp, issue_rd,
        input  q_fp, q_rs, q_rt,
        output rs_busy, rt_busy,
        output wr_en, wr_fp, wr_addr, wr_data,
        output fifo_count
    );

    modport master (
        output flush,
        output alu_valid, alu_fp, alu_rd, alu_data,
        output lu_valid, lu_fp, lu_rd, lu_data,
        input  lu_ready,
        output issue_valid, issue_fp, issue_rd,
        output q_fp, q_rs, q_rt,
        input  rs_busy, rt_busy,
        input  wr_en, wr_fp, wr_addr, wr_data,
        input  fifo_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Purpose : merges ALU and long-unit results onto one register-file write port; tracks pending long-unit dests.
// Latency : ALU result -> wr_* in 1 cycle; long-unit handshake -> wr_* in >= 2 cycles (FIFO, no bypass).
// Backpressure: lu_ready = !full & !flush (low in reset); ALU always wins arbitration, so ALU traffic stalls the FIFO drain.
//
// Ports:
//   clk    clock, all state on posedge
//   reset  asynchronous active-low reset
//   wb     regfile_writeback_if.slave (see interface file for signal list)
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    regfile_writeback_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic        fp;
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_entry_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Scoreboard index is {fp, rd}: bits 0..31 int bank, 32..63 fp bank.
    logic [63:0]   pend_q, pend_d;

    logic          wr_en_q, wr_en_d;
    logic          wr_fp_q, wr_fp_d;
    logic [4:0]    wr_addr_q, wr_addr_d;
    logic [31:0]   wr_data_q, wr_data_d;

    // ---------------------------------------------------------------
    // Handshake and arbitration decisions
    // ---------------------------------------------------------------
    logic      full;
    logic      empty;
    logic      lu_rdy;
    logic      push;
    logic      pop;
    logic      issue_set;
    wb_entry_t head;
    wb_entry_t push_ent;

    always_comb begin
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        // reset term keeps ready low for the whole time reset is held,
        // not just until the counter has been cleared.
        lu_rdy    = reset & ~full & ~wb.flush;
        push      = wb.lu_valid & lu_rdy;
        // ALU has no backpressure, so it takes the write port first and
        // the FIFO only drains in ALU-idle cycles.
        pop       = ~wb.flush & ~wb.alu_valid & ~empty;
        head      = mem_q[rd_ptr_q];
        push_ent  = '{fp: wb.lu_fp, rd: wb.lu_rd, dat: wb.lu_data};
        // int r0 is hardwired zero and can never be a hazard source.
        issue_set = wb.issue_valid & ~wb.flush & (wb.issue_fp | (wb.issue_rd != 5'd0));
    end

    // ---------------------------------------------------------------
    // Long-unit result FIFO
    // ---------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wb.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_ent;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            // push while full is blocked by lu_ready, pop while empty by
            // the empty term in pop, so the counter never wraps.
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Write-port selection
    // ---------------------------------------------------------------
    always_comb begin
        wr_en_d   = 1'b0;
        wr_fp_d   = wr_fp_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        // ALU still writes during a flush: it is not a buffered result.
        if (wb.alu_valid) begin
            if (wb.alu_fp || (wb.alu_rd != 5'd0)) begin
                wr_en_d   = 1'b1;
                wr_fp_d   = wb.alu_fp;
                wr_addr_d = wb.alu_rd;
                wr_data_d = wb.alu_data;
            end
        end else if (pop) begin
            // A popped int r0 result is consumed but never written.
            if (head.fp || (head.rd != 5'd0)) begin
                wr_en_d   = 1'b1;
                wr_fp_d   = head.fp;
                wr_addr_d = head.rd;
                wr_data_d = head.dat;
            end
        end
    end

    // ---------------------------------------------------------------
    // Pending-write scoreboard
    // ---------------------------------------------------------------
    always_comb begin
        pend_d = pend_q;
        if (wb.flush) begin
            pend_d = '0;
        end else begin
            if (pop) begin
                pend_d[{head.fp, head.rd}] = 1'b0;
            end
            // Applied after the clear so a newer in-flight op on the same
            // register keeps the bit set.
            if (issue_set) begin
                pend_d[{wb.issue_fp, wb.issue_rd}] = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pend_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_fp_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pend_q    <= pend_d;
            wr_en_q   <= wr_en_d;
            wr_fp_q   <= wr_fp_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign wb.lu_ready   = lu_rdy;
    assign wb.rs_busy    = pend_q[{wb.q_fp, wb.q_rs}];
    assign wb.rt_busy    = pend_q[{wb.q_fp, wb.q_rt}];
    assign wb.wr_en      = wr_en_q;
    assign wb.wr_fp      = wr_fp_q;
    assign wb.wr_addr    = wr_addr_q;
    assign wb.wr_data    = wr_data_q;
    assign wb.fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Purpose : directed bench for regfile_writeback with hand-computed expectations.
// Latency : inputs driven 1 time unit after posedge, outputs sampled there too.
// Backpressure: exercised by filling the FIFO under continuous ALU traffic.
module tb_regfile_writeback;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_err;

    regfile_writeback_if #(.DEPTH(4)) wb_if ();

    regfile_writeback #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        reset             = 1'b1;
        wb_if.flush       = 1'b0;
        wb_if.alu_valid   = 1'b0;
        wb_if.alu_fp      = 1'b0;
        wb_if.alu_rd      = 5'd0;
        wb_if.alu_data    = 32'h0;
        wb_if.lu_valid    = 1'b1;
        wb_if.lu_fp       = 1'b0;
        wb_if.lu_rd       = 5'd1;
        wb_if.lu_data     = 32'hAAAA;
        wb_if.issue_valid = 1'b0;
        wb_if.issue_fp    = 1'b0;
        wb_if.issue_rd    = 5'd0;
        wb_if.q_fp        = 1'b0;
        wb_if.q_rs        = 5'd1;
        wb_if.q_rt        = 5'd2;

        // ---- 1: reset with lu_valid held high ----
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lu_ready", wb_if.lu_ready, 0);
        chk("rst_wr_en", wb_if.wr_en, 0);
        chk("rst_count", wb_if.fifo_count, 0);
        chk("rst_wr_addr", wb_if.wr_addr, 0);
        chk("rst_wr_data", wb_if.wr_data, 0);
        chk("rst_rs_busy_int", wb_if.rs_busy, 0);
        wb_if.q_fp = 1'b1;
        #1;
        chk("rst_rt_busy_fp", wb_if.rt_busy, 0);
        wb_if.lu_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_lu_ready", wb_if.lu_ready, 1);

        // ---- 2: ALU write int r5 ----
        step();
        wb_if.alu_valid = 1'b1;
        wb_if.alu_fp    = 1'b0;
        wb_if.alu_rd    = 5'd5;
        wb_if.alu_data  = 32'h1234;
        step();
        wb_if.alu_valid = 1'b0;
        chk("alu_wr_en", wb_if.wr_en, 1);
        chk("alu_wr_fp", wb_if.wr_fp, 0);
        chk("alu_wr_addr", wb_if.wr_addr, 5);
        chk("alu_wr_data", wb_if.wr_data, 32'h1234);
        step();
        chk("idle_wr_en", wb_if.wr_en, 0);
        chk("idle_addr_hold", wb_if.wr_addr, 5);
        chk("idle_data_hold", wb_if.wr_data, 32'h1234);

        // ---- 3: issue fp r3, long-unit result for fp r3 ----
        wb_if.issue_valid = 1'b1;
        wb_if.issue_fp    = 1'b1;
        wb_if.issue_rd    = 5'd3;
        step();
        wb_if.issue_valid = 1'b0;
        wb_if.q_fp = 1'b1;
        wb_if.q_rs = 5'd3;
        wb_if.q_rt = 5'd4;
        #1;
        chk("iss_rs_busy", wb_if.rs_busy, 1);
        chk("iss_rt_busy", wb_if.rt_busy, 0);
        wb_if.lu_valid = 1'b1;
        wb_if.lu_fp    = 1'b1;
        wb_if.lu_rd    = 5'd3;
        wb_if.lu_data  = 32'h3F800000;
        #1;
        chk("lu_ready_empty", wb_if.lu_ready, 1);
        step();
        wb_if.lu_valid = 1'b0;
        chk("lu_count1", wb_if.fifo_count, 1);
        chk("lu_no_bypass", wb_if.wr_en, 0);
        chk("lu_busy_before_pop", wb_if.rs_busy, 1);
        step();
        chk("lu_wr_en", wb_if.wr_en, 1);
        chk("lu_wr_fp", wb_if.wr_fp, 1);
        chk("lu_wr_addr", wb_if.wr_addr, 3);
        chk("lu_wr_data", wb_if.wr_data, 32'h3F800000);
        chk("lu_count0", wb_if.fifo_count, 0);
        chk("lu_busy_cleared", wb_if.rs_busy, 0);

        // ---- 4: fill FIFO under ALU traffic, then drain ----
        wb_if.alu_valid = 1'b1;
        wb_if.alu_fp    = 1'b0;
        wb_if.alu_rd    = 5'd10;
        wb_if.alu_data  = 32'hA;
        for (int i = 0; i < 4; i++) begin
            wb_if.lu_valid = 1'b1;
            wb_if.lu_fp    = 1'b0;
            wb_if.lu_rd    = 5'(11 + i);
            wb_if.lu_data  = 32'(32'h100 + i);
            step();
        end
        chk("fill_count4", wb_if.fifo_count, 4);
        chk("fill_alu_wr_addr", wb_if.wr_addr, 10);
        wb_if.lu_rd   = 5'd15;
        wb_if.lu_data = 32'h1FF;
        #1;
        chk("full_lu_ready", wb_if.lu_ready, 0);
        step();
        chk("full_no_push", wb_if.fifo_count, 4);
        wb_if.alu_valid = 1'b0;
        wb_if.lu_valid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("drain%0d_wr_en", i), wb_if.wr_en, 1);
            chk($sformatf("drain%0d_wr_addr", i), wb_if.wr_addr, 64'(11 + i));
            chk($sformatf("drain%0d_wr_data", i), wb_if.wr_data, 64'(32'h100 + i));
            chk($sformatf("drain%0d_count", i), wb_if.fifo_count, 64'(3 - i));
        end
        step();
        chk("drain_done_wr_en", wb_if.wr_en, 0);

        // ---- 5: same-cycle pop and issue of fp r7, plus push+pop ----
        wb_if.issue_valid = 1'b1;
        wb_if.issue_fp    = 1'b1;
        wb_if.issue_rd    = 5'd7;
        step();
        wb_if.issue_valid = 1'b0;
        wb_if.lu_valid    = 1'b1;
        wb_if.lu_fp       = 1'b1;
        wb_if.lu_rd       = 5'd7;
        wb_if.lu_data     = 32'h77;
        step();
        wb_if.issue_valid = 1'b1;
        wb_if.issue_fp    = 1'b1;
        wb_if.issue_rd    = 5'd7;
        wb_if.lu_rd       = 5'd8;
        wb_if.lu_data     = 32'h88;
        step();
        wb_if.issue_valid = 1'b0;
        wb_if.lu_valid    = 1'b0;
        chk("sc_wr_addr", wb_if.wr_addr, 7);
        chk("sc_wr_data", wb_if.wr_data, 32'h77);
        chk("sc_pushpop_count", wb_if.fifo_count, 1);
        wb_if.q_fp = 1'b1;
        wb_if.q_rs = 5'd7;
        wb_if.q_rt = 5'd8;
        #1;
        chk("sc_set_wins", wb_if.rs_busy, 1);
        chk("sc_rt_clear", wb_if.rt_busy, 0);
        step();
        chk("sc2_wr_addr", wb_if.wr_addr, 8);
        chk("sc2_wr_data", wb_if.wr_data, 32'h88);
        chk("sc2_count", wb_if.fifo_count, 0);
        chk("sc2_busy7", wb_if.rs_busy, 1);

        // ---- fp r0 is an ordinary register ----
        wb_if.alu_valid = 1'b1;
        wb_if.alu_fp    = 1'b1;
        wb_if.alu_rd    = 5'd0;
        wb_if.alu_data  = 32'h55;
        step();
        wb_if.alu_valid = 1'b0;
        chk("fpr0_wr_en", wb_if.wr_en, 1);
        chk("fpr0_wr_fp", wb_if.wr_fp, 1);
        chk("fpr0_wr_addr", wb_if.wr_addr, 0);
        chk("fpr0_wr_data", wb_if.wr_data, 32'h55);

        // ---- 6: flush with 3 entries and 2 busy bits ----
        wb_if.issue_valid = 1'b1;
        wb_if.issue_fp    = 1'b0;
        wb_if.issue_rd    = 5'd2;
        step();
        wb_if.issue_rd    = 5'd0;
        step();
        wb_if.issue_valid = 1'b0;
        wb_if.q_fp = 1'b0;
        wb_if.q_rs = 5'd0;
        wb_if.q_rt = 5'd2;
        #1;
        chk("intr0_never_busy", wb_if.rs_busy, 0);
        chk("int2_busy", wb_if.rt_busy, 1);
        wb_if.alu_valid = 1'b1;
        wb_if.alu_fp    = 1'b0;
        wb_if.alu_rd    = 5'd20;
        wb_if.alu_data  = 32'h20;
        for (int i = 0; i < 3; i++) begin
            wb_if.lu_valid = 1'b1;
            wb_if.lu_fp    = 1'b0;
            wb_if.lu_rd    = 5'(21 + i);
            wb_if.lu_data  = 32'(32'h200 + i);
            step();
        end
        wb_if.lu_valid = 1'b0;
        chk("pre_flush_count", wb_if.fifo_count, 3);
        chk("pre_flush_wr_en", wb_if.wr_en, 1);
        wb_if.flush       = 1'b1;
        wb_if.alu_rd      = 5'd0;
        wb_if.alu_data    = 32'hDEAD;
        wb_if.lu_valid    = 1'b1;
        wb_if.lu_rd       = 5'd24;
        wb_if.issue_valid = 1'b1;
        wb_if.issue_fp    = 1'b0;
        wb_if.issue_rd    = 5'd9;
        #1;
        chk("flush_lu_ready", wb_if.lu_ready, 0);
        step();
        wb_if.flush       = 1'b0;
        wb_if.alu_valid   = 1'b0;
        wb_if.lu_valid    = 1'b0;
        wb_if.issue_valid = 1'b0;
        chk("flush_intr0_wr_en", wb_if.wr_en, 0);
        chk("flush_count", wb_if.fifo_count, 0);
        wb_if.q_fp = 1'b1;
        wb_if.q_rs = 5'd7;
        wb_if.q_rt = 5'd3;
        #1;
        chk("flush_fp7_clear", wb_if.rs_busy, 0);
        wb_if.q_fp = 1'b0;
        wb_if.q_rs = 5'd2;
        wb_if.q_rt = 5'd9;
        #1;
        chk("flush_int2_clear", wb_if.rs_busy, 0);
        chk("flush_issue_ignored", wb_if.rt_busy, 0);
        step();
        chk("post_flush_wr_en", wb_if.wr_en, 0);
        step();
        chk("post_flush2_wr_en", wb_if.wr_en, 0);
        chk("post_flush_count", wb_if.fifo_count, 0);

        // ---- reset mid-operation ----
        wb_if.lu_valid    = 1'b1;
        wb_if.lu_fp       = 1'b0;
        wb_if.lu_rd       = 5'd25;
        wb_if.lu_data     = 32'h250;
        wb_if.issue_valid = 1'b1;
        wb_if.issue_fp    = 1'b0;
        wb_if.issue_rd    = 5'd25;
        step();
        wb_if.lu_valid    = 1'b0;
        wb_if.issue_valid = 1'b0;
        wb_if.q_fp = 1'b0;
        wb_if.q_rs = 5'd25;
        chk("mid_count1", wb_if.fifo_count, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_count", wb_if.fifo_count, 0);
        chk("mid_rst_busy", wb_if.rs_busy, 0);
        chk("mid_rst_lu_ready", wb_if.lu_ready, 0);
        reset = 1'b1;
        step();
        chk("mid_rst_no_write", wb_if.wr_en, 0);
        chk("mid_rst_count_after", wb_if.fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
